// File: rtl/uart_tx_scheduler_if.sv
// uart_tx_scheduler_if: requester byte handshake plus the UART transmitter register bus.
// master = scheduler side, slave = requesters/transmitter side.
interface uart_tx_scheduler_if #(parameter int NUM_REQ = 4);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [8*NUM_REQ-1:0] req_data;
    logic [31:0]          uart_addr;
    logic                 uart_wr_en;
    logic [7:0]           uart_raw_data;
    logic [13:0]          uart_baud_divisor;
    logic                 uart_tx_en;
    logic                 uart_two_stop;
    logic                 uart_odd_parity;
    logic                 uart_byte_done;
    modport master (
        input  req_valid, req_last, req_data, uart_byte_done,
        output req_ready, uart_addr, uart_wr_en, uart_raw_data, uart_baud_divisor,
               uart_tx_en, uart_two_stop, uart_odd_parity
    );
    modport slave (
        output req_valid, req_last, req_data, uart_byte_done,
        input  req_ready, uart_addr, uart_wr_en, uart_raw_data, uart_baud_divisor,
               uart_tx_en, uart_two_stop, uart_odd_parity
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin, packet-granular sharing of one UART transmitter with FIFO credit tracking.
// Define UART_SCHED_TIMEOUT_EN to release a grant whose requester stays idle for TIMEOUT_CYC cycles.
module uart_tx_scheduler #(
    parameter int          NUM_REQ     = 4,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [31:0] DATA_ADDR   = 32'd0,
    parameter logic [31:0] CTRL_ADDR   = 32'd1,
    parameter logic [31:0] BAUD_ADDR   = 32'd3,
    parameter int          TIMEOUT_CYC = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_start_i,
    input  logic [13:0]         cfg_baud_i,
    input  logic                cfg_two_stop_i,
    input  logic                cfg_odd_parity_i,
    output logic                cfg_done_o,
    output logic                grant_valid_o,
    output logic [2:0]          grant_id_o,
    uart_tx_scheduler_if.master bus
);
    localparam int            CW   = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
    localparam logic [3:0]    NR   = 4'(NUM_REQ);

    typedef enum logic [2:0] {UNCFG, CFG_BAUD, CFG_CTRL, ARB, SEND} state_e;
    state_e state_q, state_d;

    logic [7:0]    valid_pad, last_pad;
    logic [63:0]   data_pad;
    logic [2:0]    rr_q, rr_d, gnt_q, gnt_d, pick;
    logic [3:0]    s;
    logic          any_valid, cur_valid, accept, timeout, release_g, cfg_go;
    logic [CW-1:0] credit_q, credit_d;
    logic [13:0]   baud_q;
    logic          two_stop_q, odd_q;
    logic          tx_en_q, tx_en_d, wr_en_q, wr_en_d;
    logic          cfg_done_q, cfg_done_d, gvalid_q, gvalid_d;
    logic [31:0]   addr_q, addr_d;
    logic [7:0]    data_q, data_d;

    assign valid_pad = 8'(bus.req_valid);
    assign last_pad  = 8'(bus.req_last);
    assign data_pad  = 64'(bus.req_data);
    assign cur_valid = valid_pad[gnt_q];
    assign accept    = state_q == SEND && cur_valid && credit_q != '0;
    assign release_g = (accept && last_pad[gnt_q]) || timeout;
    assign cfg_go    = cfg_start_i && (state_q == UNCFG || state_q == ARB);

`ifdef UART_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] idle_q;
    // Counts idle cycles of the granted requester; the TIMEOUT_CYC-th idle cycle releases the grant.
    assign timeout = state_q == SEND && !cur_valid && idle_q == TW'(TIMEOUT_CYC - 1);
    always_ff @(posedge clk)
        if (reset || state_q != SEND || accept || timeout) idle_q <= '0;
        else if (!cur_valid) idle_q <= idle_q + TW'(1);
`else
    assign timeout = 1'b0;
`endif

    // First valid requester at or after the rr pointer; lowest offset wins.
    always_comb begin
        pick      = '0;
        any_valid = 1'b0;
        s         = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            s = {1'b0, rr_q} + 4'(k);
            if (s >= NR) s = s - NR;
            if (valid_pad[s[2:0]]) begin
                pick      = s[2:0];
                any_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) state_q <= reset ? UNCFG : state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            UNCFG:    state_d = cfg_start_i ? CFG_BAUD : UNCFG;
            CFG_BAUD: state_d = CFG_CTRL;
            CFG_CTRL: state_d = ARB;
            ARB:      state_d = cfg_start_i ? CFG_BAUD : any_valid ? SEND : ARB;
            SEND:     state_d = release_g ? ARB : SEND;
            default:  state_d = UNCFG;
        endcase
    end

    // Bus outputs are registered: each decision shows up on the bus the following cycle.
    always_comb begin
        wr_en_d    = state_q == CFG_BAUD || state_q == CFG_CTRL || accept;
        addr_d     = state_q == CFG_BAUD ? BAUD_ADDR : state_q == CFG_CTRL ? CTRL_ADDR : accept ? DATA_ADDR : '0;
        data_d     = accept ? data_pad[{gnt_q, 3'b000} +: 8] : '0;
        tx_en_d    = tx_en_q || state_q == CFG_CTRL;
        cfg_done_d = cfg_done_q || state_q == CFG_CTRL;
        gvalid_d   = state_d == SEND;
        gnt_d      = state_q == ARB && state_d == SEND ? pick : gnt_q;
        rr_d       = release_g ? (gnt_q == 3'(NUM_REQ - 1) ? 3'd0 : gnt_q + 3'd1) : rr_q;
        credit_d   = cfg_go ? FULL
                   : accept && !bus.uart_byte_done ? credit_q - CW'(1)
                   : !accept && bus.uart_byte_done && credit_q != FULL ? credit_q + CW'(1)
                   : credit_q;
    end

    always_ff @(posedge clk)
        if (reset) begin
            credit_q   <= FULL;
            rr_q       <= '0;
            gnt_q      <= '0;
            gvalid_q   <= 1'b0;
            cfg_done_q <= 1'b0;
            tx_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            baud_q     <= '0;
            two_stop_q <= 1'b0;
            odd_q      <= 1'b0;
        end else begin
            credit_q   <= credit_d;
            rr_q       <= rr_d;
            gnt_q      <= gnt_d;
            gvalid_q   <= gvalid_d;
            cfg_done_q <= cfg_done_d;
            tx_en_q    <= tx_en_d;
            wr_en_q    <= wr_en_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            if (cfg_go) begin
                baud_q     <= cfg_baud_i;
                two_stop_q <= cfg_two_stop_i;
                odd_q      <= cfg_odd_parity_i;
            end
        end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_ready
        assign bus.req_ready[i] = accept && gnt_q == 3'(i);
    end

    assign bus.uart_wr_en        = wr_en_q;
    assign bus.uart_addr         = addr_q;
    assign bus.uart_raw_data     = data_q;
    assign bus.uart_baud_divisor = baud_q;
    assign bus.uart_tx_en        = tx_en_q;
    assign bus.uart_two_stop     = two_stop_q;
    assign bus.uart_odd_parity   = odd_q;
    assign cfg_done_o            = cfg_done_q;
    assign grant_valid_o         = gvalid_q;
    assign grant_id_o            = gnt_q;
endmodule
